mem_lsu: RTL and testbench

Memory-access stage load/store unit. It sits between the execute stage and the mem-to-writeback pipeline register, and its mem2wb_* outputs drive that register directly. It issues data-memory requests over a req/ready handshake, aligns and sign-extends load data, and builds byte enables for stores. It also detects misaligned accesses and bus timeouts, and drives mem_stall/readram_stall so that bubbles are inserted into the mem-to-writeback register while an access is outstanding.

---
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
interface mem_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage load/store unit: issues data-memory requests, aligns
// and extends load data, builds store byte enables, flags misaligned
// accesses and bus timeouts, and stalls the mem-to-writeback register while
// an access is outstanding.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        exe2mem_load,
    input  logic        exe2mem_store,
    input  logic [2:0]  exe2mem_funct3,
    input  logic [31:0] exe2mem_addr,
    input  logic [31:0] exe2mem_wdata,
    input  logic [31:0] exe2mem_alu_res,
    input  logic        exe2mem_wr_reg,
    input  logic [4:0]  exe2mem_wr_regindex,
    input  logic        exe2mem_exp,
    input  logic        flush,
    mem_lsu_if.master   dmem,
    output logic        mem_stall,
    output logic        readram_stall,
    output logic        mem2wb_wr_reg,
    output logic [4:0]  mem2wb_wr_regindex,
    output logic [31:0] mem2wb_wr_wdata,
    output logic        mem2wb_exp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  to_cnt;
    logic        kill;
    logic        bus_err;
    logic [31:0] rdata_q;
    logic        ld_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        misalign_raw;
    logic        misaligned;
    logic        access;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // Alignment check and the access qualifier for the instruction in IDLE
    always_comb begin
        misalign_raw = 1'b0;
        case (exe2mem_funct3[1:0])
            2'b01:   misalign_raw = exe2mem_addr[0];
            2'b10:   misalign_raw = |exe2mem_addr[1:0];
            default: misalign_raw = 1'b0;
        endcase
        misaligned = (exe2mem_load | exe2mem_store) & misalign_raw;
        access     = (exe2mem_load | exe2mem_store) & ~exe2mem_exp & ~flush & ~misalign_raw;
    end

    // Store byte enables and lane-replicated store data
    always_comb begin
        store_be   = 4'b1111;
        store_data = exe2mem_wdata;
        case (exe2mem_funct3[1:0])
            2'b00: begin
                store_be   = 4'b0001 << exe2mem_addr[1:0];
                store_data = {4{exe2mem_wdata[7:0]}};
            end
            2'b01: begin
                store_be   = exe2mem_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{exe2mem_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = exe2mem_wdata;
            end
        endcase
    end

    // Select and extend the loaded byte/halfword using the captured offset
    always_comb begin
        ld_byte = rdata_q[7:0];
        case (off_q)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = rdata_q;
        endcase
    end

    // FSM and request registers; the request is held until ready or timeout
    always_ff @(posedge clk) begin
        if (cpurst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            to_cnt   <= 8'h0;
            kill     <= 1'b0;
            bus_err  <= 1'b0;
            rdata_q  <= 32'h0;
            ld_q     <= 1'b0;
            funct3_q <= 3'b0;
            off_q    <= 2'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state    <= BUSY;
                        req_q    <= 1'b1;
                        we_q     <= exe2mem_store;
                        addr_q   <= {exe2mem_addr[31:2], 2'b00};
                        be_q     <= exe2mem_store ? store_be : 4'b1111;
                        wdata_q  <= store_data;
                        ld_q     <= exe2mem_load;
                        funct3_q <= exe2mem_funct3;
                        off_q    <= exe2mem_addr[1:0];
                        to_cnt   <= 8'h0;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (dmem.dmem_ready) begin
                        rdata_q <= dmem.dmem_rdata;
                        req_q   <= 1'b0;
                        state   <= DONE;
                    end else if (to_cnt == 8'(TIMEOUT - 1)) begin
                        bus_err <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    to_cnt  <= 8'h0;
                    kill    <= 1'b0;
                    bus_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall generation and the mem-to-writeback outputs for each state
    always_comb begin
        mem_stall          = 1'b0;
        readram_stall      = 1'b0;
        mem2wb_wr_reg      = 1'b0;
        mem2wb_wr_regindex = exe2mem_wr_regindex;
        mem2wb_wr_wdata    = exe2mem_alu_res;
        mem2wb_exp         = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    mem_stall     = 1'b1;
                    readram_stall = exe2mem_load;
                end else begin
                    mem2wb_exp    = exe2mem_exp | misaligned;
                    mem2wb_wr_reg = exe2mem_wr_reg & ~(exe2mem_exp | misaligned);
                end
            end
            BUSY: begin
                mem_stall     = 1'b1;
                readram_stall = ld_q;
            end
            DONE: begin
                if (ld_q) begin
                    mem2wb_wr_wdata = load_data;
                end
                mem2wb_exp    = bus_err & ~kill;
                mem2wb_wr_reg = exe2mem_wr_reg & ld_q & ~bus_err & ~kill & ~flush;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard testbench for mem_lsu: directed vectors push expected bus
// requests and writeback results; independent monitors pop and compare.
module tb_mem_lsu;

    logic        clk;
    logic        cpurst;
    logic        exe2mem_load;
    logic        exe2mem_store;
    logic [2:0]  exe2mem_funct3;
    logic [31:0] exe2mem_addr;
    logic [31:0] exe2mem_wdata;
    logic [31:0] exe2mem_alu_res;
    logic        exe2mem_wr_reg;
    logic [4:0]  exe2mem_wr_regindex;
    logic        exe2mem_exp;
    logic        flush;
    logic        mem_stall;
    logic        readram_stall;
    logic        mem2wb_wr_reg;
    logic [4:0]  mem2wb_wr_regindex;
    logic [31:0] mem2wb_wr_wdata;
    logic        mem2wb_exp;

    mem_lsu_if dmem ();

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk                 (clk),
        .cpurst              (cpurst),
        .exe2mem_load        (exe2mem_load),
        .exe2mem_store       (exe2mem_store),
        .exe2mem_funct3      (exe2mem_funct3),
        .exe2mem_addr        (exe2mem_addr),
        .exe2mem_wdata       (exe2mem_wdata),
        .exe2mem_alu_res     (exe2mem_alu_res),
        .exe2mem_wr_reg      (exe2mem_wr_reg),
        .exe2mem_wr_regindex (exe2mem_wr_regindex),
        .exe2mem_exp         (exe2mem_exp),
        .flush               (flush),
        .dmem                (dmem.master),
        .mem_stall           (mem_stall),
        .readram_stall       (readram_stall),
        .mem2wb_wr_reg       (mem2wb_wr_reg),
        .mem2wb_wr_regindex  (mem2wb_wr_regindex),
        .mem2wb_wr_wdata     (mem2wb_wr_wdata),
        .mem2wb_exp          (mem2wb_exp)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] alu;
        logic        wr;
        logic [4:0]  idx;
        logic        uexp;
        logic        fl_idle;
        int          delay;
        logic [31:0] rdat;
        int          flush_at;
        logic        e_wr;
        logic [31:0] e_wdata;
        logic        e_exp;
        logic        chk_wr;
        logic        chk_wdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_bwdata;
        int          e_stalls;
        int          e_reqs;
    } vec_t;

    typedef struct {
        int          id;
        logic        e_wr;
        logic [4:0]  e_idx;
        logic [31:0] e_wdata;
        logic        e_exp;
        logic        chk_wr;
        logic        chk_wdata;
    } res_t;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    res_t  res_q[$];
    req_t  req_q[$];
    vec_t  vecs[$];

    int          checks;
    int          failures;
    logic        active;
    int          ready_delay;
    logic [31:0] cur_rdata;
    int          busy_cnt;
    logic        prev_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
        end
    endtask

    // Memory model: raises ready after ready_delay request cycles (-1 = never)
    always @(negedge clk) begin
        if (dmem.dmem_req) begin
            if (ready_delay >= 0 && busy_cnt == ready_delay) begin
                dmem.dmem_ready = 1'b1;
                dmem.dmem_rdata = cur_rdata;
            end else begin
                dmem.dmem_ready = 1'b0;
            end
            busy_cnt++;
        end else begin
            dmem.dmem_ready = 1'b0;
            busy_cnt = 0;
        end
    end

    // Bus monitor: every new request is compared against the queued expectation
    always @(negedge clk) begin
        if (dmem.dmem_req && !prev_req) begin
            if (req_q.size() == 0) begin
                checkOutput("unexpected_req", 32'd1, 32'd0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                checkOutput($sformatf("v%0d.we", r.id), 32'(dmem.dmem_we), 32'(r.we));
                checkOutput($sformatf("v%0d.addr", r.id), dmem.dmem_addr, r.addr);
                checkOutput($sformatf("v%0d.be", r.id), 32'(dmem.dmem_be), 32'(r.be));
                if (r.we) begin
                    checkOutput($sformatf("v%0d.bus_wdata", r.id), dmem.dmem_wdata, r.wdata);
                end
            end
        end
        prev_req = dmem.dmem_req;
    end

    // Result monitor: an unstalled cycle with an instruction present retires it
    always @(negedge clk) begin
        if (active && !mem_stall) begin
            if (res_q.size() == 0) begin
                checkOutput("unexpected_retire", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = res_q.pop_front();
                checkOutput($sformatf("v%0d.idx", e.id), 32'(mem2wb_wr_regindex), 32'(e.e_idx));
                checkOutput($sformatf("v%0d.exp", e.id), 32'(mem2wb_exp), 32'(e.e_exp));
                if (e.chk_wr) begin
                    checkOutput($sformatf("v%0d.wr_reg", e.id), 32'(mem2wb_wr_reg), 32'(e.e_wr));
                end
                if (e.chk_wdata) begin
                    checkOutput($sformatf("v%0d.wdata", e.id), mem2wb_wr_wdata, e.e_wdata);
                end
            end
        end
    end

    task automatic idleInputs();
        exe2mem_load        = 1'b0;
        exe2mem_store       = 1'b0;
        exe2mem_funct3      = 3'b010;
        exe2mem_addr        = 32'h0;
        exe2mem_wdata       = 32'h0;
        exe2mem_alu_res     = 32'h0;
        exe2mem_wr_reg      = 1'b0;
        exe2mem_wr_regindex = 5'd0;
        exe2mem_exp         = 1'b0;
        flush               = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input vec_t v);
        res_t r;
        req_t q;
        int   cyc;
        int   stalls;
        int   reqs;
        bit   done;
        @(posedge clk);
        #1;
        ready_delay         = v.delay;
        cur_rdata           = v.rdat;
        exe2mem_load        = v.ld;
        exe2mem_store       = v.st;
        exe2mem_funct3      = v.f3;
        exe2mem_addr        = v.addr;
        exe2mem_wdata       = v.wdat;
        exe2mem_alu_res     = v.alu;
        exe2mem_wr_reg      = v.wr;
        exe2mem_wr_regindex = v.idx;
        exe2mem_exp         = v.uexp;
        flush               = v.fl_idle;
        r = '{id, v.e_wr, v.idx, v.e_wdata, v.e_exp, v.chk_wr, v.chk_wdata};
        res_q.push_back(r);
        if (v.e_req) begin
            q = '{id, v.e_we, v.e_addr, v.e_be, v.e_bwdata};
            req_q.push_back(q);
        end
        active = 1'b1;
        cyc    = 0;
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            if (dmem.dmem_req) reqs++;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                flush = (cyc == v.flush_at);
            end
        end
        if (!done) begin
            checkOutput($sformatf("v%0d.retire_timeout", id), 32'd0, 32'd1);
        end
        checkOutput($sformatf("v%0d.stall_cycles", id), 32'(stalls), 32'(v.e_stalls));
        checkOutput($sformatf("v%0d.req_cycles", id), 32'(reqs), 32'(v.e_reqs));
        @(posedge clk);
        #1;
        active = 1'b0;
        idleInputs();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        active      = 1'b0;
        ready_delay = 0;
        cur_rdata   = 32'h0;
        busy_cnt    = 0;
        prev_req    = 1'b0;
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'h0;
        idleInputs();
        cpurst = 1'b1;

        //            ld st f3      addr          wdat          alu           wr idx   ue fi dly rdat          fa ewr e_wdata      eexp cw cd req we e_addr        e_be     e_bwdata      st rq
        vecs.push_back('{1, 0, 3'b010, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 0, 0, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        2, 1});
        vecs.push_back('{1, 0, 3'b000, 32'h00000103, 32'h0,        32'h0,        1, 5'd5, 0, 0, 0, 32'h80FFFF7F, 0, 1, 32'hFFFFFF80, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        2, 1});
        vecs.push_back('{1, 0, 3'b100, 32'h00000103, 32'h0,        32'h0,        1, 5'd5, 0, 0, 0, 32'h80FFFF7F, 0, 1, 32'h00000080, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        2, 1});
        vecs.push_back('{1, 0, 3'b101, 32'h00000102, 32'h0,        32'h0,        1, 5'd5, 0, 0, 0, 32'h80FFFF7F, 0, 1, 32'h000080FF, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        2, 1});
        vecs.push_back('{1, 0, 3'b000, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 0, 0, 0, 32'h80FFFF7F, 0, 1, 32'h0000007F, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        2, 1});
        vecs.push_back('{1, 0, 3'b001, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 0, 0, 2, 32'h12348001, 0, 1, 32'hFFFF8001, 0, 1, 1, 1, 0, 32'h00000100, 4'b1111, 32'h0,        4, 3});
        vecs.push_back('{0, 1, 3'b000, 32'h00000101, 32'h123456AB, 32'h0,        1, 5'd5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 1, 32'h00000100, 4'b0010, 32'hABABABAB, 2, 1});
        vecs.push_back('{0, 1, 3'b001, 32'h00000102, 32'h0000BEEF, 32'h0,        1, 5'd5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 1, 32'h00000100, 4'b1100, 32'hBEEFBEEF, 2, 1});
        vecs.push_back('{0, 1, 3'b010, 32'h00000104, 32'hCAFEF00D, 32'h0,        1, 5'd5, 0, 0, 1, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 1, 32'h00000104, 4'b1111, 32'hCAFEF00D, 3, 2});
        vecs.push_back('{1, 0, 3'b010, 32'h00000102, 32'h0,        32'h00000011, 1, 5'd5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});
        vecs.push_back('{1, 0, 3'b001, 32'h00000101, 32'h0,        32'h00000011, 1, 5'd5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});
        vecs.push_back('{0, 1, 3'b001, 32'h00000103, 32'h0000BEEF, 32'h0,        1, 5'd5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});
        vecs.push_back('{0, 0, 3'b000, 32'h00000000, 32'h0,        32'h00000055, 1, 5'd7, 0, 0, 0, 32'h0,        0, 1, 32'h00000055, 0, 1, 1, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});
        vecs.push_back('{1, 0, 3'b010, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});
        vecs.push_back('{1, 0, 3'b010, 32'h00000200, 32'h0,        32'h0,        1, 5'd5, 0, 0, -1, 32'h0,       0, 0, 32'h0,        1, 1, 0, 1, 0, 32'h00000200, 4'b1111, 32'h0,        17, 16});
        vecs.push_back('{1, 0, 3'b010, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 0, 0, 3, 32'h11111111, 3, 0, 32'h0,        0, 1, 0, 1, 0, 32'h00000100, 4'b1111, 32'h0,        5, 4});
        vecs.push_back('{1, 0, 3'b010, 32'h00000100, 32'h0,        32'h0,        1, 5'd5, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0});

        repeat (3) @(posedge clk);
        #1;
        cpurst = 1'b0;
        @(negedge clk);
        checkOutput("reset.req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("reset.we", 32'(dmem.dmem_we), 32'd0);
        checkOutput("reset.addr", dmem.dmem_addr, 32'h0);
        checkOutput("reset.wdata", dmem.dmem_wdata, 32'h0);
        checkOutput("reset.be", 32'(dmem.dmem_be), 32'd0);
        checkOutput("reset.stall", 32'(mem_stall), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Reset in the middle of an outstanding request drops it
        @(posedge clk);
        #1;
        ready_delay         = -1;
        exe2mem_load        = 1'b1;
        exe2mem_funct3      = 3'b010;
        exe2mem_addr        = 32'h00000300;
        exe2mem_wr_reg      = 1'b1;
        exe2mem_wr_regindex = 5'd9;
        req_q.push_back('{100, 1'b0, 32'h00000300, 4'b1111, 32'h0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstmid.busy_req", 32'(dmem.dmem_req), 32'd1);
        checkOutput("rstmid.busy_rdstall", 32'(readram_stall), 32'd1);
        @(posedge clk);
        #1;
        cpurst = 1'b1;
        idleInputs();
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid.req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("rstmid.stall", 32'(mem_stall), 32'd0);
        checkOutput("rstmid.be", 32'(dmem.dmem_be), 32'd0);

        // A normal load after the mid-request reset
        applyStimulus(101, vecs[0]);

        repeat (3) @(posedge clk);
        checkOutput("end.res_q_empty", 32'(res_q.size()), 32'd0);
        checkOutput("end.req_q_empty", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
